// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
package uart_boot_loader_pkg;

  // Frame parser states (3-bit encoding)
  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Frame layout: two length bytes, then four bytes per word
  localparam int HDR_BYTES        = 2;
  localparam int BYTES_PER_WORD   = 4;

  // 12 MHz clock at 115200 baud
  localparam int DEF_CLKS_PER_BIT = 104;

endpackage

// File: rtl/uart_boot_loader_if.sv
// RAM write port driven by the boot loader until the image is loaded.
interface uart_boot_loader_if #(
  parameter int ADDR_W = 14
);
  // ram_we is a single-cycle strobe; ram_addr/ram_di are valid only while
  // ram_we is high. There is no back-pressure: the RAM must accept every
  // strobe in the cycle it is presented.
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_di;
  logic              ram_we;

  modport master (output ram_addr, ram_di, ram_we);
  modport slave  (input  ram_addr, ram_di, ram_we);
endinterface

// File: rtl/uart_boot_loader_rx_byte.sv
// 8N1 UART byte receiver: synchronizer, mid-bit sampling, stop-bit check.
module uart_rx_byte
  import uart_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF  = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_BITS, R_STOP, R_WAIT_HIGH
  } rx_state_t;

  rx_state_t  rstate;
  logic       s1, s2, s3;
  logic [CNT_W-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Bit timing and character assembly; strobes are one cycle wide
  always_ff @(posedge clk) begin
    if (reset) begin
      rstate    <= R_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (rstate)
        R_IDLE: begin
          cnt <= '0;
          if (s3 && !s2) rstate <= R_START;
        end
        R_START: begin
          if (cnt == CNT_W'(HALF - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            // Line back high at mid start bit: treat as a glitch
            rstate  <= s2 ? R_IDLE : R_BITS;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        R_BITS: begin
          if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            shreg <= {s2, shreg[7:1]};
            if (bit_idx == 3'd7) rstate <= R_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        R_STOP: begin
          if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt <= '0;
            if (s2) begin
              rx_valid <= 1'b1;
              rx_data  <= shreg;
              rstate   <= R_IDLE;
            end else begin
              frame_err <= 1'b1;
              rstate    <= R_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        R_WAIT_HIGH: begin
          if (s2) rstate <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a length/data/checksum frame over UART and writes it to RAM.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int ADDR_W       = 14,
  parameter int MAX_WORDS    = 16384,
  parameter int TIMEOUT_CLKS = 1200000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                uart_rx,
  uart_boot_loader_if.master  ram,
  output logic                boot,
  output logic                busy,
  output logic                err,
  output state_t              state
);

  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             frame_err;

  logic [15:0]      len;
  logic [7:0]       csum;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]       lane;
  logic [23:0]      shreg;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]      di_q;
  logic             we_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             abort;
  logic [15:0]      len_full;
  logic             last_word;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (uart_rx),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .frame_err (frame_err)
  );

  assign busy      = (state == S_LEN1) || (state == S_DATA) || (state == S_CSUM);
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1));
  // A received byte always takes precedence over a timeout in the same cycle
  assign abort     = busy && !rx_valid && (frame_err || tmo_hit);
  assign len_full  = {rx_data, len[7:0]};
  assign last_word = (17'(word_idx) + 17'd1) == 17'(len);

  assign ram.ram_addr = addr_q;
  assign ram.ram_di   = di_q;
  assign ram.ram_we   = we_q;

  // Frame parser, word assembler, checksum and inter-byte timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_LEN0;
      len      <= '0;
      csum     <= '0;
      word_idx <= '0;
      lane     <= '0;
      shreg    <= '0;
      addr_q   <= '0;
      di_q     <= '0;
      we_q     <= 1'b0;
      boot     <= 1'b0;
      err      <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      we_q <= 1'b0;
      if (busy && !rx_valid) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else tmo_cnt <= '0;

      if (abort) begin
        err   <= 1'b1;
        state <= S_LEN0;
      end else begin
        case (state)
          S_LEN0: begin
            word_idx <= '0;
            lane     <= '0;
            if (rx_valid) begin
              len[7:0] <= rx_data;
              csum     <= rx_data;
              err      <= 1'b0;
              state    <= S_LEN1;
            end
          end
          S_LEN1: begin
            if (rx_valid) begin
              len[15:8] <= rx_data;
              csum      <= csum + rx_data;
              if (17'(len_full) > 17'(MAX_WORDS)) begin
                err   <= 1'b1;
                state <= S_LEN0;
              end else if (len_full == 16'd0) begin
                state <= S_CSUM;
              end else begin
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (rx_valid) begin
              csum <= csum + rx_data;
              case (lane)
                2'd0: shreg[7:0]   <= rx_data;
                2'd1: shreg[15:8]  <= rx_data;
                2'd2: shreg[23:16] <= rx_data;
                default: begin
                  we_q     <= 1'b1;
                  addr_q   <= word_idx;
                  di_q     <= {rx_data, shreg};
                  word_idx <= word_idx + ADDR_W'(1);
                  if (last_word) state <= S_CSUM;
                end
              endcase
              lane <= (lane == 2'(BYTES_PER_WORD - 1)) ? 2'd0 : lane + 2'd1;
            end
          end
          S_CSUM: begin
            if (rx_valid) begin
              if (rx_data == csum) begin
                boot  <= 1'b1;
                state <= S_DONE;
              end else begin
                err   <= 1'b1;
                state <= S_LEN0;
              end
            end
          end
          S_DONE: boot <= 1'b1;
          default: state <= S_LEN0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for the UART boot loader.
module tb_uart_boot_loader;
  import uart_boot_loader_pkg::*;

  localparam int CPB       = 4;
  localparam int ADDR_W    = 14;
  localparam int MAX_WORDS = 16384;
  localparam int TMO       = 200;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   uart_rx = 1'b1;
  logic   boot, busy, err;
  state_t state;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] got_q[$];

  uart_boot_loader_if #(.ADDR_W(ADDR_W)) ram ();

  uart_boot_loader #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (ADDR_W),
    .MAX_WORDS    (MAX_WORDS),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .uart_rx (uart_rx),
    .ram     (ram),
    .boot    (boot),
    .busy    (busy),
    .err     (err),
    .state   (state)
  );

  // Clock
  always #5 clk = ~clk;

  // Capture every RAM write strobe
  always @(negedge clk) begin
    if (!reset && ram.ram_we) got_q.push_back({ram.ram_addr, ram.ram_di});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare captured writes with the expected queue, then clear both
  task automatic check_writes(input string tag);
    int n;
    check({tag, " nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s wr%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_clks(CPB);
    end
    uart_rx = stop;
    wait_clks(CPB);
    uart_rx = 1'b1;
    if (!stop) wait_clks(2 * CPB);
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i], 1'b1);
  endtask

  function automatic logic [7:0] sum8(input logic [7:0] q[$]);
    logic [7:0] s = 8'h00;
    foreach (q[i]) s = s + q[i];
    return s;
  endfunction

  task automatic do_reset();
    reset   = 1'b1;
    uart_rx = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(2);
    got_q.delete();
    exp_q.delete();
  endtask

  logic [7:0] f1[$];
  logic [7:0] cs1;

  initial begin
    f1  = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    cs1 = sum8(f1);
    @(negedge clk);

    // Reset state
    do_reset();
    check("rst boot", 64'(boot), 64'(0));
    check("rst err", 64'(err), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst we", 64'(ram.ram_we), 64'(0));
    check("rst state", 64'(state), 64'(S_LEN0));
    check("rst csum model", 64'(cs1), 64'(8'hE4));

    // 1: good two-word frame
    exp_q.push_back({14'd0, 32'h11223344});
    exp_q.push_back({14'd1, 32'hDEADBEEF});
    send_bytes(f1);
    send_byte(cs1, 1'b1);
    wait_clks(10);
    check_writes("t1");
    check("t1 boot", 64'(boot), 64'(1));
    check("t1 err", 64'(err), 64'(0));
    check("t1 state", 64'(state), 64'(S_DONE));
    check("t1 busy", 64'(busy), 64'(0));
    // Traffic after boot is ignored
    send_bytes('{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04});
    wait_clks(10);
    check_writes("t1 post");
    check("t1 post boot", 64'(boot), 64'(1));

    // 2: bad checksum, then a correct resend
    do_reset();
    exp_q.push_back({14'd0, 32'h11223344});
    exp_q.push_back({14'd1, 32'hDEADBEEF});
    send_bytes(f1);
    send_byte(cs1 + 8'd1, 1'b1);
    wait_clks(10);
    check_writes("t2");
    check("t2 boot", 64'(boot), 64'(0));
    check("t2 err", 64'(err), 64'(1));
    check("t2 state", 64'(state), 64'(S_LEN0));
    send_byte(8'h02, 1'b1);
    wait_clks(4);
    check("t2 err clr", 64'(err), 64'(0));
    check("t2 state len1", 64'(state), 64'(S_LEN1));
    exp_q.push_back({14'd0, 32'h11223344});
    exp_q.push_back({14'd1, 32'hDEADBEEF});
    send_bytes('{8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
    send_byte(cs1, 1'b1);
    wait_clks(10);
    check_writes("t2 resend");
    check("t2 resend boot", 64'(boot), 64'(1));
    check("t2 resend err", 64'(err), 64'(0));

    // 3: zero-length image
    do_reset();
    send_bytes('{8'h00, 8'h00, 8'h00});
    wait_clks(10);
    check_writes("t3");
    check("t3 boot", 64'(boot), 64'(1));
    check("t3 err", 64'(err), 64'(0));

    // 4: length one above the limit, then exactly at the limit
    do_reset();
    send_bytes('{8'h01, 8'h40});
    wait_clks(10);
    check_writes("t4");
    check("t4 err", 64'(err), 64'(1));
    check("t4 state", 64'(state), 64'(S_LEN0));
    send_bytes('{8'h00, 8'h40});
    wait_clks(10);
    check("t4 max err", 64'(err), 64'(0));
    check("t4 max state", 64'(state), 64'(S_DATA));

    // 5: timeout with a partial word pending
    do_reset();
    send_bytes('{8'h01, 8'h00, 8'h44, 8'h33, 8'h22});
    wait_clks(100);
    check("t5 mid err", 64'(err), 64'(0));
    check("t5 mid busy", 64'(busy), 64'(1));
    wait_clks(150);
    check_writes("t5");
    check("t5 err", 64'(err), 64'(1));
    check("t5 state", 64'(state), 64'(S_LEN0));
    // One-cycle glitch must not produce a byte
    uart_rx = 1'b0;
    wait_clks(1);
    uart_rx = 1'b1;
    wait_clks(20);
    check("t5 glitch state", 64'(state), 64'(S_LEN0));
    send_bytes('{8'h00, 8'h00, 8'h00});
    wait_clks(10);
    check("t5 glitch boot", 64'(boot), 64'(1));
    check("t5 glitch err", 64'(err), 64'(0));

    // 6: framing error mid-data, then reset mid-data
    do_reset();
    send_bytes('{8'h01, 8'h00, 8'h44});
    send_byte(8'h33, 1'b0);
    wait_clks(10);
    check_writes("t6");
    check("t6 err", 64'(err), 64'(1));
    check("t6 state", 64'(state), 64'(S_LEN0));
    exp_q.push_back({14'd0, 32'h11223344});
    send_bytes('{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h55});
    wait_clks(10);
    check_writes("t6 pre");
    check("t6 pre state", 64'(state), 64'(S_DATA));
    check("t6 pre di", 64'(ram.ram_di), 64'(32'h11223344));
    reset = 1'b1;
    wait_clks(1);
    check("t6 rst we", 64'(ram.ram_we), 64'(0));
    check("t6 rst di", 64'(ram.ram_di), 64'(0));
    check("t6 rst addr", 64'(ram.ram_addr), 64'(0));
    check("t6 rst busy", 64'(busy), 64'(0));
    check("t6 rst boot", 64'(boot), 64'(0));
    check("t6 rst err", 64'(err), 64'(0));
    check("t6 rst state", 64'(state), 64'(S_LEN0));
    reset = 1'b0;
    wait_clks(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
